// File: rtl/onehot_decoder.sv
// onehot_decoder: registered binary index to one-hot strobes, asynchronous active-high reset.
// Define DECODER_DOUT_V_EN to add the dout_v output (din_v delayed by one cycle).
module onehot_decoder #(
  parameter int DOUT_WIDTH = 16,
  parameter int DIN_WIDTH  = $clog2(DOUT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_v,
`ifdef DECODER_DOUT_V_EN
  output logic                  dout_v,
`endif
  output logic [DOUT_WIDTH-1:0] dout
);
  logic [DOUT_WIDTH-1:0] dec;
  logic [DOUT_WIDTH-1:0] dout_d, dout_q;
  // An out-of-range index matches no lane, so it decodes to all zeros.
  always_comb begin
    dec = '0;
    for (int i = 0; i < DOUT_WIDTH; i++) dec[i] = din == DIN_WIDTH'(i);
  end
  assign dout_d = din_v ? dec : dout_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end
  assign dout = dout_q;
`ifdef DECODER_DOUT_V_EN
  logic dout_v_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_v_q <= 1'b0;
    else     dout_v_q <= din_v;
  end
  assign dout_v = dout_v_q;
`endif
endmodule

// File: tb/tb_onehot_decoder.sv
// tb_onehot_decoder: vector table, hand sequences and randomized checks against a behavioural model.
// Exercises a 16-lane instance and a 10-lane instance for out-of-range indices.
module tb_onehot_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = 4'd5;
  logic        din_v = 1'b1;
  logic [15:0] dout;
  logic [9:0]  dout10;
  logic        dv16, dv10;
  int checks = 0;
  int errors = 0;
  logic [15:0] m16 = '0;
  logic [9:0]  m10 = '0;
  logic        mv = 1'b0;

  always #5 clk = ~clk;

  onehot_decoder #(.DOUT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_v(din_v),
`ifdef DECODER_DOUT_V_EN
    .dout_v(dv16),
`endif
    .dout(dout)
  );

  onehot_decoder #(.DOUT_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .din(din), .din_v(din_v),
`ifdef DECODER_DOUT_V_EN
    .dout_v(dv10),
`endif
    .dout(dout10)
  );

`ifndef DECODER_DOUT_V_EN
  assign dv16 = 1'b0;
  assign dv10 = 1'b0;
`endif

  typedef struct {
    logic [3:0]  din;
    logic        din_v;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value the decoder should present after an edge, from the rules alone.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m16 = '0; m10 = '0; mv = 1'b0;
    end else begin
      if (din_v) begin
        m16 = 16'(32'd1 << din);
        m10 = (int'(din) < 10) ? 10'(32'd1 << din) : '0;
      end
      mv = din_v;
    end
    #1;
  endtask

  task automatic check_model(input string name);
    check({name, "/dout16"}, 32'(dout), 32'(m16));
    check({name, "/dout10"}, 32'(dout10), 32'(m10));
`ifdef DECODER_DOUT_V_EN
    check({name, "/dout_v16"}, 32'(dv16), 32'(mv));
    check({name, "/dout_v10"}, 32'(dv10), 32'(mv));
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) vecs.push_back('{4'(i), 1'b1, 16'(32'd1 << i)});
    vecs.push_back('{4'd3, 1'b1, 16'h0008});
    for (int i = 0; i < 5; i++) vecs.push_back('{4'd9, 1'b0, 16'h0008});
    vecs.push_back('{4'd15, 1'b1, 16'h8000});
    vecs.push_back('{4'd0, 1'b0, 16'h8000});

    #1;
    check("reset_t0", 32'(dout), 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("reset_hold", 32'(dout), 32'h0);
      check_model("reset_hold");
    end

    rst = 1'b0; din = 4'd0; din_v = 1'b1;
    tick();
    check("first_after_reset", 32'(dout), 32'h0001);

    foreach (vecs[k]) begin
      din = vecs[k].din; din_v = vecs[k].din_v;
      tick();
      check($sformatf("vec%0d", k), 32'(dout), 32'(vecs[k].exp));
      check_model($sformatf("vec%0d", k));
    end

    din = 4'd10; din_v = 1'b1;
    tick();
    check("pre_async", 32'(dout), 32'h0400);
    check("oor_10", 32'(dout10), 32'h0);
    #2 rst = 1'b1;
    #1;
    m16 = '0; m10 = '0; mv = 1'b0;
    check("async_clear", 32'(dout), 32'h0);
    check_model("async_clear");
    tick();
    rst = 1'b0; din_v = 1'b0; din = 4'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_release_idle", 32'(dout), 32'h0);
      check_model("post_release_idle");
    end
    din_v = 1'b1;
    tick();
    check("post_release_load", 32'(dout), 32'h0080);
    din = 4'd12;
    tick();
    check("oor_12_w10", 32'(dout10), 32'h0);
    check("in_range_12_w16", 32'(dout), 32'h1000);

    for (int c = 0; c < 300; c++) begin
      din = 4'($urandom_range(0, 15));
      din_v = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 29) == 0);
      tick();
      check_model("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
